// File: rtl/multi_button_debounce_pkg.sv
// Shared defaults and constants for the multi-channel button debouncer.
package multi_button_debounce_pkg;

  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_WIDTH   = 16;
  localparam int DEF_HOLD_WIDTH  = 24;

  // Value the synchroniser chain holds out of reset: "button not pressed".
  localparam logic SYNC_RESET_VAL = 1'b0;

  localparam int IDX_WIDTH = (DEF_CHANNELS > 1) ? $clog2(DEF_CHANNELS) : 1;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce filter, long-press counter,
// one-cycle event pulses and a sticky event flag.
module debounce_channel
  import multi_button_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int HOLD_WIDTH  = DEF_HOLD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn,
  input  logic [CNT_WIDTH-1:0]  debounce_limit,
  input  logic [HOLD_WIDTH-1:0] hold_limit,
  input  logic                  flag_clr,
  output logic                  state,
  output logic                  press_pulse,
  output logic                  release_pulse,
  output logic                  long_press_pulse,
  output logic                  event_flag
);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [HOLD_WIDTH-1:0]  hold_cnt;
  logic [HOLD_WIDTH-1:0]  hold_inc;
  logic                   sample;
  logic                   toggle;
  logic                   hold_sat;
  logic                   press_nxt;
  logic                   long_nxt;

  assign sample    = sync[SYNC_STAGES-1];
  // >= rather than == so a threshold lowered mid-count still terminates.
  assign toggle    = (sample != state) && (cnt >= debounce_limit);
  assign press_nxt = toggle && !state;
  assign hold_sat  = &hold_cnt;
  assign hold_inc  = hold_cnt + 1'b1;
  // Fires only on the step onto H, so a held button yields one pulse.
  assign long_nxt  = state && !hold_sat && (hold_limit != '0) && (hold_inc == hold_limit);

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, as real registers do.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync             <= {SYNC_STAGES{SYNC_RESET_VAL}};
      cnt              <= '0;
      hold_cnt         <= '0;
      state            <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      event_flag       <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};

      if (sample == state || toggle) cnt <= '0;
      else                           cnt <= cnt + 1'b1;

      if (toggle) state <= !state;
      press_pulse   <= press_nxt;
      release_pulse <= toggle && state;

      if (!state)        hold_cnt <= '0;
      else if (!hold_sat) hold_cnt <= hold_inc;
      long_press_pulse <= long_nxt;

      // A set on the same edge as a clear wins.
      if (press_nxt || long_nxt) event_flag <= 1'b1;
      else if (flag_clr)         event_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_button_debounce.sv
// N independent debounced button channels with a registered combined interrupt.
module multi_button_debounce
  import multi_button_debounce_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int HOLD_WIDTH  = DEF_HOLD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   btn_in,
  input  logic [CNT_WIDTH-1:0]  debounce_limit,
  input  logic [HOLD_WIDTH-1:0] hold_limit,
  input  logic [CHANNELS-1:0]   flag_clr,
  output logic [CHANNELS-1:0]   btn_state,
  output logic [CHANNELS-1:0]   press_pulse,
  output logic [CHANNELS-1:0]   release_pulse,
  output logic [CHANNELS-1:0]   long_press_pulse,
  output logic [CHANNELS-1:0]   event_flags,
  output logic                  irq
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_WIDTH   (CNT_WIDTH),
      .HOLD_WIDTH  (HOLD_WIDTH)
    ) u_ch (
      .clk              (clk),
      .rst              (rst),
      .btn              (btn_in[i]),
      .debounce_limit   (debounce_limit),
      .hold_limit       (hold_limit),
      .flag_clr         (flag_clr[i]),
      .state            (btn_state[i]),
      .press_pulse      (press_pulse[i]),
      .release_pulse    (release_pulse[i]),
      .long_press_pulse (long_press_pulse[i]),
      .event_flag       (event_flags[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) irq <= 1'b0;
    else      irq <= |event_flags;
  end

endmodule

// File: tb/tb_multi_button_debounce.sv
// Directed bench for multi_button_debounce with default parameters.
module tb_multi_button_debounce;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn_in;
  logic [15:0] debounce_limit;
  logic [23:0] hold_limit;
  logic [3:0]  flag_clr;
  logic [3:0]  btn_state;
  logic [3:0]  press_pulse;
  logic [3:0]  release_pulse;
  logic [3:0]  long_press_pulse;
  logic [3:0]  event_flags;
  logic        irq;

  int checks = 0;
  int errors = 0;

  multi_button_debounce dut (
    .clk              (clk),
    .rst              (rst),
    .btn_in           (btn_in),
    .debounce_limit   (debounce_limit),
    .hold_limit       (hold_limit),
    .flag_clr         (flag_clr),
    .btn_state        (btn_state),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse),
    .event_flags      (event_flags),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int early;
    int extra;
    int longs;
    int bounce_changes;

    rst            = 1'b0;
    btn_in         = '0;
    debounce_limit = 16'd3;
    hold_limit     = 24'd0;
    flag_clr       = '0;
    tick(2);
    check("reset_state", btn_state, 4'h0);
    check("reset_flags", event_flags, 4'h0);
    check("reset_irq", irq, 1'b0);
    check("reset_pulses", {press_pulse, release_pulse, long_press_pulse}, 12'h0);
    rst = 1'b1;
    tick();

    // Clean press on ch0 with L=3: rises on edge 6.
    btn_in[0] = 1'b1;
    tick(5);
    check("l3_state_e5", btn_state, 4'h0);
    check("l3_press_e5", press_pulse, 4'h0);
    tick();
    check("l3_state_e6", btn_state, 4'h1);
    check("l3_press_e6", press_pulse, 4'h1);
    check("l3_flag_e6", event_flags, 4'h1);
    check("l3_irq_e6", irq, 1'b0);
    tick();
    check("l3_press_e7", press_pulse, 4'h0);
    check("l3_irq_e7", irq, 1'b1);

    // Clear alone: flag drops after the edge, irq one edge later.
    flag_clr[0] = 1'b1;
    tick();
    flag_clr[0] = 1'b0;
    check("clr_flag", event_flags, 4'h0);
    check("clr_irq_lag", irq, 1'b1);
    tick();
    check("clr_irq", irq, 1'b0);

    // Bounce on ch1 with L=10.
    debounce_limit = 16'd10;
    bounce_changes = 0;
    for (int k = 0; k < 10; k++) begin
      btn_in[1] = (k % 2 == 0);
      for (int c = 0; c < 4; c++) begin
        tick();
        if (btn_state[1] || press_pulse[1]) bounce_changes++;
      end
    end
    check("bounce_no_change", bounce_changes, 0);
    btn_in[1] = 1'b1;
    tick(12);
    check("bounce_state_e12", btn_state[1], 1'b0);
    tick();
    check("bounce_state_e13", btn_state[1], 1'b1);
    check("bounce_press_e13", press_pulse, 4'h2);

    // Release ch0/ch1 with L=0: edge 3.
    debounce_limit = 16'd0;
    btn_in[1:0]    = 2'b00;
    tick(2);
    check("rel_state_e2", btn_state, 4'h3);
    tick();
    check("rel_pulse_e3", release_pulse, 4'h3);
    check("rel_state_e3", btn_state, 4'h0);
    check("rel_no_press", press_pulse, 4'h0);

    // Long press on ch2, H=100.
    hold_limit = 24'd100;
    btn_in[2]  = 1'b1;
    tick(3);
    check("lp_press", press_pulse, 4'h4);
    early = 0;
    for (int c = 0; c < 99; c++) begin
      tick();
      if (long_press_pulse != 4'h0) early++;
    end
    check("lp_none_early", early, 0);
    tick();
    check("lp_pulse_h", long_press_pulse, 4'h4);
    extra = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (long_press_pulse != 4'h0) extra++;
    end
    check("lp_once", extra, 0);

    // H=0 disables long press.
    btn_in[2]  = 1'b0;
    hold_limit = 24'd0;
    tick(3);
    check("lp_release", release_pulse, 4'h4);
    btn_in[3] = 1'b1;
    longs = 0;
    for (int c = 0; c < 150; c++) begin
      tick();
      if (long_press_pulse != 4'h0) longs++;
    end
    check("h0_no_long", longs, 0);
    check("h0_state", btn_state, 4'h8);
    btn_in[3] = 1'b0;
    tick(3);
    flag_clr = 4'hF;
    tick();
    flag_clr = 4'h0;
    check("flags_cleared", event_flags, 4'h0);

    // Clear race: clear on the press edge leaves the flag set.
    btn_in[0] = 1'b1;
    tick(2);
    flag_clr[0] = 1'b1;
    tick();
    flag_clr[0] = 1'b0;
    check("race_press", press_pulse, 4'h1);
    check("race_flag", event_flags, 4'h1);
    tick();
    check("race_flag_hold", event_flags, 4'h1);
    check("race_irq", irq, 1'b1);

    // Reset mid-hold (ch0) and mid-count (ch1).
    debounce_limit = 16'd10;
    hold_limit     = 24'd100;
    btn_in[1]      = 1'b1;
    tick(5);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_mid_state", btn_state, 4'h0);
    check("rst_mid_flags", event_flags, 4'h0);
    check("rst_mid_irq", irq, 1'b0);
    check("rst_mid_pulses", {press_pulse, release_pulse, long_press_pulse}, 12'h0);
    tick(12);
    check("repress_e12", btn_state, 4'h0);
    tick();
    check("repress_e13_state", btn_state, 4'h3);
    check("repress_e13_press", press_pulse, 4'h3);

    debounce_limit = 16'd0;
    btn_in = 4'h0;
    tick(3);
    check("rel_after_rst", release_pulse, 4'h3);
    flag_clr = 4'hF;
    tick();
    flag_clr = 4'h0;
    tick();
    check("irq_idle", irq, 1'b0);

    // All channels simultaneously.
    btn_in = 4'hF;
    tick(3);
    check("all_press", press_pulse, 4'hF);
    check("all_state", btn_state, 4'hF);
    check("all_flags", event_flags, 4'hF);
    tick();
    check("all_irq", irq, 1'b1);
    check("all_press_gone", press_pulse, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
